// File: rtl/window_hash_pkg.sv
// Shared types, defaults and reference hash for the Bloom-index window hash pipeline.
// The reference function computes the full-window hash in one pass, for models and checks.
package window_hash_pkg;

    localparam int BYTE_W        = 8;
    localparam int WINDOW_SIZE   = 20;
    localparam int WINDOW_SIZE_W = $clog2(WINDOW_SIZE) + 1;
    localparam int HASH_W        = 16;
    localparam int ROT           = 5;
    localparam logic [HASH_W-1:0] SEED = 16'h1F3D;

    typedef logic [HASH_W-1:0]                  hash_t;
    typedef logic [WINDOW_SIZE_W-1:0]           len_t;
    typedef logic [WINDOW_SIZE-1:0][BYTE_W-1:0] window_t;

    function automatic hash_t rotl_hash(input hash_t h);
        return (h << ROT) | (h >> (HASH_W - ROT));
    endfunction

    // Counts above the window size are illegal upstream; clamp instead of wrapping.
    function automatic len_t sat_len(input len_t len);
        if (len > len_t'(WINDOW_SIZE)) begin
            return len_t'(WINDOW_SIZE);
        end
        return len;
    endfunction

    function automatic hash_t ref_window_hash(input window_t data, input len_t len);
        len_t  l;
        hash_t h;
        l = sat_len(len);
        h = SEED;
        for (int k = 0; k < WINDOW_SIZE; k++) begin
            h = rotl_hash(h) ^ ((k < int'(l)) ? hash_t'(data[k]) : hash_t'(0));
        end
        return h ^ hash_t'(l);
    endfunction

endpackage

// File: rtl/window_hash_stage.sv
// One pipeline stage: folds window bytes FIRST_BYTE..LAST_BYTE into the running hash of every lane.
// The stage folding the final window byte also mixes in the lane's byte count.
module window_hash_stage
    import window_hash_pkg::*;
#(
    parameter int SYMBOLS    = 8,
    parameter int FIRST_BYTE = 0,
    parameter int LAST_BYTE  = 3
) (
    input  logic                                              clk_i,
    input  logic                                              srst_n_i,
    input  logic                                              advance_i,
    input  logic                                              valid_i,
    input  logic [SYMBOLS-1:0][LAST_BYTE-FIRST_BYTE:0][BYTE_W-1:0] bytes_i,
    input  logic [SYMBOLS-1:0][WINDOW_SIZE_W-1:0]             len_i,
    input  logic [SYMBOLS-1:0][HASH_W-1:0]                    hash_i,
    output logic                                              valid_o,
    output logic [SYMBOLS-1:0][WINDOW_SIZE_W-1:0]             len_o,
    output logic [SYMBOLS-1:0][HASH_W-1:0]                    hash_o
);

    localparam bit IS_LAST = (LAST_BYTE == WINDOW_SIZE - 1);

    logic [SYMBOLS-1:0][HASH_W-1:0] hash_d;

    always_comb begin
        hash_d = '0;
        for (int l = 0; l < SYMBOLS; l++) begin
            hash_d[l] = hash_i[l];
            // Bytes at or beyond the lane's valid count fold in as zero.
            for (int j = 0; j <= LAST_BYTE - FIRST_BYTE; j++) begin
                hash_d[l] = rotl_hash(hash_d[l]) ^
                            ((FIRST_BYTE + j < int'(len_i[l])) ? hash_t'(bytes_i[l][j]) : hash_t'(0));
            end
            if (IS_LAST) begin
                hash_d[l] = hash_d[l] ^ hash_t'(len_i[l]);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            valid_o <= 1'b0;
        end else if (advance_i) begin
            valid_o <= valid_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (advance_i) begin
            len_o  <= len_i;
            hash_o <= hash_d;
        end
    end

endmodule

// File: rtl/window_hash_pipe.sv
// Per-lane Bloom index hash over byte windows, pipelined NUM_STAGES deep with backpressure.
// Optional statistics counters are enabled with the macro WINDOW_HASH_PIPE_STAT_EN.
module window_hash_pipe
    import window_hash_pkg::*;
#(
    parameter int AST_SINK_SYMBOLS = 8,
    parameter int BYTES_PER_STAGE  = 4
) (
    input  logic                                                     clk_i,
    input  logic                                                     srst_n_i,
    input  logic [AST_SINK_SYMBOLS-1:0][WINDOW_SIZE-1:0][BYTE_W-1:0] windows_data_i,
    input  logic [AST_SINK_SYMBOLS-1:0][WINDOW_SIZE_W-1:0]           windows_valid_bytes_i,
    output logic                                                     windows_ready_o,
    output logic [AST_SINK_SYMBOLS-1:0][HASH_W-1:0]                  hash_o,
    output logic [AST_SINK_SYMBOLS-1:0]                              hash_lane_en_o,
    output logic                                                     hash_valid_o,
    input  logic                                                     hash_ready_i
`ifdef WINDOW_HASH_PIPE_STAT_EN
    ,
    output logic [31:0]                                              stat_beats_o,
    output logic [31:0]                                              stat_stall_o
`endif
);

    localparam int SYM        = AST_SINK_SYMBOLS;
    localparam int NUM_STAGES = (WINDOW_SIZE + BYTES_PER_STAGE - 1) / BYTES_PER_STAGE;

    // Handshake: the output beat transfers on a clock edge where hash_valid_o && hash_ready_i.
    // Upstream always presents a beat and it is taken on any edge where windows_ready_o is high;
    // the pipe advances as a whole whenever the output slot is empty or being drained.
    logic advance;
    logic beat_valid;
    logic [SYM-1:0][WINDOW_SIZE_W-1:0] len_sat;

    logic [NUM_STAGES:0]                                stg_valid;
    logic [NUM_STAGES:0][SYM-1:0][WINDOW_SIZE_W-1:0]    stg_len;
    logic [NUM_STAGES:0][SYM-1:0][HASH_W-1:0]           stg_hash;

    assign advance         = !hash_valid_o || hash_ready_i;
    assign windows_ready_o = advance;

    always_comb begin
        beat_valid = 1'b0;
        len_sat    = '0;
        for (int l = 0; l < SYM; l++) begin
            len_sat[l] = sat_len(windows_valid_bytes_i[l]);
            beat_valid = beat_valid | (windows_valid_bytes_i[l] != '0);
        end
    end

    assign stg_valid[0] = beat_valid;
    assign stg_len[0]   = len_sat;
    assign stg_hash[0]  = {SYM{SEED}};

    for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
        localparam int FIRST = s * BYTES_PER_STAGE;
        localparam int LAST  = (((s + 1) * BYTES_PER_STAGE < WINDOW_SIZE) ?
                                (s + 1) * BYTES_PER_STAGE : WINDOW_SIZE) - 1;
        localparam int NB    = LAST - FIRST + 1;
        localparam int REM   = WINDOW_SIZE - FIRST;

        // Window bytes not yet folded when a beat reaches this stage; index 0 is byte FIRST.
        logic [SYM-1:0][REM-1:0][BYTE_W-1:0] rem;
        logic [SYM-1:0][NB-1:0][BYTE_W-1:0]  fold_bytes;

        if (s == 0) begin : g_src
            assign rem = windows_data_i;
        end else begin : g_reg
            always_ff @(posedge clk_i) begin
                if (advance) begin
                    for (int l = 0; l < SYM; l++) begin
                        rem[l] <= g_stage[s-1].rem[l][REM+BYTES_PER_STAGE-1:BYTES_PER_STAGE];
                    end
                end
            end
        end

        always_comb begin
            fold_bytes = '0;
            for (int l = 0; l < SYM; l++) begin
                fold_bytes[l] = rem[l][NB-1:0];
            end
        end

        window_hash_stage #(
            .SYMBOLS    (SYM),
            .FIRST_BYTE (FIRST),
            .LAST_BYTE  (LAST)
        ) u_stage (
            .clk_i     (clk_i),
            .srst_n_i  (srst_n_i),
            .advance_i (advance),
            .valid_i   (stg_valid[s]),
            .bytes_i   (fold_bytes),
            .len_i     (stg_len[s]),
            .hash_i    (stg_hash[s]),
            .valid_o   (stg_valid[s+1]),
            .len_o     (stg_len[s+1]),
            .hash_o    (stg_hash[s+1])
        );
    end

    assign hash_valid_o = stg_valid[NUM_STAGES];

    // Gating by the reset-cleared valid bit keeps outputs at zero without resetting data registers.
    always_comb begin
        hash_lane_en_o = '0;
        hash_o         = '0;
        for (int l = 0; l < SYM; l++) begin
            if (hash_valid_o && (stg_len[NUM_STAGES][l] != '0)) begin
                hash_lane_en_o[l] = 1'b1;
                hash_o[l]         = stg_hash[NUM_STAGES][l];
            end
        end
    end

`ifdef WINDOW_HASH_PIPE_STAT_EN
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            stat_beats_o <= '0;
            stat_stall_o <= '0;
        end else begin
            if (advance && beat_valid) begin
                stat_beats_o <= stat_beats_o + 32'd1;
            end
            if (hash_valid_o && !hash_ready_i) begin
                stat_stall_o <= stat_stall_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_window_hash_pipe.sv
// Self-checking bench for window_hash_pipe: directed cases plus randomized beats with random backpressure.
// Expected beats are queued at acceptance and compared by an independent output monitor.
module tb_window_hash_pipe;
    import window_hash_pkg::*;

    localparam int SYM   = 8;
    localparam int EXP_W = SYM * HASH_W + SYM;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                                       srst_n_i;
    logic [SYM-1:0][WINDOW_SIZE-1:0][BYTE_W-1:0] windows_data_i;
    logic [SYM-1:0][WINDOW_SIZE_W-1:0]           windows_valid_bytes_i;
    logic                                       windows_ready_o;
    logic [SYM-1:0][HASH_W-1:0]                  hash_o;
    logic [SYM-1:0]                              hash_lane_en_o;
    logic                                       hash_valid_o;
    logic                                       hash_ready_i;
`ifdef WINDOW_HASH_PIPE_STAT_EN
    logic [31:0]                                stat_beats_o;
    logic [31:0]                                stat_stall_o;
`endif

    window_hash_pipe dut (
        .clk_i                 (clk),
        .srst_n_i              (srst_n_i),
        .windows_data_i        (windows_data_i),
        .windows_valid_bytes_i (windows_valid_bytes_i),
        .windows_ready_o       (windows_ready_o),
        .hash_o                (hash_o),
        .hash_lane_en_o        (hash_lane_en_o),
        .hash_valid_o          (hash_valid_o),
        .hash_ready_i          (hash_ready_i)
`ifdef WINDOW_HASH_PIPE_STAT_EN
        ,
        .stat_beats_o          (stat_beats_o),
        .stat_stall_o          (stat_stall_o)
`endif
    );

    int n_vec  = 0;
    int n_fail = 0;
    logic [EXP_W-1:0] exp_q[$];

    logic [SYM-1:0][WINDOW_SIZE-1:0][BYTE_W-1:0] cur_data;
    logic [SYM-1:0][WINDOW_SIZE_W-1:0]           cur_len;
    logic                                       last_acc;
    logic [EXP_W-1:0]                           got;

    task automatic check(input string name, input logic [EXP_W-1:0] act, input logic [EXP_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Spec-level model: rotate-xor over the whole window with bytes past L read as zero.
    function automatic logic [HASH_W-1:0] model_hash(input logic [WINDOW_SIZE-1:0][BYTE_W-1:0] w,
                                                     input int len);
        int          l;
        int unsigned h;
        l = (len > WINDOW_SIZE) ? WINDOW_SIZE : len;
        h = 32'h1F3D;
        for (int k = 0; k < WINDOW_SIZE; k++) begin
            h = ((h << 5) | (h >> 11)) & 32'hFFFF;
            if (k < l) h = h ^ 32'(w[k]);
        end
        h = h ^ 32'(l);
        return h[HASH_W-1:0];
    endfunction

    function automatic logic [EXP_W-1:0] model_beat(input logic [SYM-1:0][WINDOW_SIZE-1:0][BYTE_W-1:0] d,
                                                    input logic [SYM-1:0][WINDOW_SIZE_W-1:0] len);
        logic [EXP_W-1:0] r;
        r = '0;
        for (int l = 0; l < SYM; l++) begin
            if (len[l] != '0) begin
                r[SYM*HASH_W + l]       = 1'b1;
                r[l*HASH_W +: HASH_W] = model_hash(d[l], int'(len[l]));
            end
        end
        return r;
    endfunction

    task automatic rand_beat(input bit nonempty, input bit allow_bubble);
        for (int l = 0; l < SYM; l++) begin
            for (int k = 0; k < WINDOW_SIZE; k++) begin
                cur_data[l][k] = 8'($urandom_range(0, 255));
            end
            if ($urandom_range(0, 3) == 0) cur_len[l] = '0;
            else cur_len[l] = WINDOW_SIZE_W'($urandom_range(1, 22));
        end
        if (allow_bubble && !nonempty && $urandom_range(0, 7) == 0) cur_len = '0;
        if (nonempty && cur_len == '0) cur_len[0] = WINDOW_SIZE_W'(1);
    endtask

    // One cycle of upstream/downstream driving; records whether the presented beat gets taken.
    task automatic drive_cycle(input logic rdy);
        @(negedge clk);
        windows_data_i        = cur_data;
        windows_valid_bytes_i = cur_len;
        hash_ready_i          = rdy;
        #1;
        check("ready_rule", EXP_W'(windows_ready_o), EXP_W'(!hash_valid_o || hash_ready_i));
        last_acc = windows_ready_o;
        if (last_acc && cur_len != '0) exp_q.push_back(model_beat(cur_data, cur_len));
    endtask

    task automatic send_beat_random_ready();
        int   tries;
        logic r;
        tries = 0;
        do begin
            r = ($urandom_range(0, 1) == 1);
            drive_cycle(r);
            tries++;
        end while (!last_acc && tries < 100);
        if (!last_acc) check("accept_timeout", EXP_W'(last_acc), EXP_W'(1));
    endtask

    task automatic idle(input int n, input logic rdy);
        cur_len = '0;
        repeat (n) drive_cycle(rdy);
    endtask

    task automatic do_reset();
        @(negedge clk);
        srst_n_i              = 1'b0;
        hash_ready_i          = 1'b0;
        cur_len               = '0;
        windows_valid_bytes_i = '0;
        exp_q.delete();
        @(negedge clk);
        srst_n_i = 1'b1;
        #1;
        check("rst_valid", EXP_W'(hash_valid_o), EXP_W'(0));
        check("rst_ready", EXP_W'(windows_ready_o), EXP_W'(1));
        check("rst_outputs", {hash_lane_en_o, hash_o}, '0);
`ifdef WINDOW_HASH_PIPE_STAT_EN
        check("rst_stats", EXP_W'({stat_beats_o, stat_stall_o}), '0);
`endif
    endtask

    // Run empty cycles after an accepted beat; report cycles until output valid and capture it.
    task automatic wait_latency(input string name, output logic [EXP_W-1:0] cap);
        int lat;
        lat = 0;
        cap = '0;
        cur_len = '0;
        for (int i = 1; i <= 8; i++) begin
            drive_cycle(1'b1);
            if (lat == 0 && hash_valid_o) begin
                lat = i;
                cap = {hash_lane_en_o, hash_o};
            end
        end
        check(name, EXP_W'(lat), EXP_W'(5));
    endtask

    // Output monitor: pops on every transfer, checks hold-stability during stalls.
    initial begin
        logic             stall_prev;
        logic [EXP_W-1:0] held;
        logic [EXP_W-1:0] e;
        stall_prev = 1'b0;
        held       = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!srst_n_i) begin
                stall_prev = 1'b0;
                continue;
            end
            if (stall_prev) begin
                check("stall_valid", EXP_W'(hash_valid_o), EXP_W'(1));
                check("stall_stable", {hash_lane_en_o, hash_o}, held);
            end
            if (hash_valid_o && hash_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", EXP_W'(hash_valid_o), EXP_W'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("hash_beat", {hash_lane_en_o, hash_o}, e);
                end
            end
            stall_prev = hash_valid_o && !hash_ready_i;
            held       = {hash_lane_en_o, hash_o};
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        srst_n_i              = 1'b0;
        hash_ready_i          = 1'b0;
        windows_data_i        = '0;
        windows_valid_bytes_i = '0;
        cur_data              = '0;
        cur_len               = '0;
        last_acc              = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();

        // Single byte in lane 0; other bytes of lane 0 are random but beyond L.
        rand_beat(1'b1, 1'b0);
        cur_len          = '0;
        cur_data[0][0]   = 8'h41;
        cur_len[0]       = WINDOW_SIZE_W'(1);
        drive_cycle(1'b1);
        check("t1_accept", EXP_W'(last_acc), EXP_W'(1));
        wait_latency("t1_latency", got);
        check("t1_lane_en", EXP_W'(got[EXP_W-1 -: SYM]), EXP_W'(8'h01));
        check("t1_hash0", EXP_W'(got[15:0]), EXP_W'(16'h73F0));

        // All-empty beats are bubbles.
        cur_len = '0;
        repeat (10) begin
            drive_cycle(1'b1);
            check("t2_ready", EXP_W'(windows_ready_o), EXP_W'(1));
            check("t2_no_valid", EXP_W'(hash_valid_o), EXP_W'(0));
        end

        // Full window vs one byte shorter with a zero last byte: only L separates them.
        rand_beat(1'b1, 1'b0);
        cur_len         = '0;
        cur_data[0][19] = 8'h00;
        cur_data[1]     = cur_data[0];
        cur_len[0]      = WINDOW_SIZE_W'(20);
        cur_len[1]      = WINDOW_SIZE_W'(19);
        drive_cycle(1'b1);
        wait_latency("t5_latency", got);
        check("t5_len_mixed", EXP_W'(got[15:0] != got[31:16]), EXP_W'(1));

        // Random traffic with random backpressure.
        repeat (64) begin
            rand_beat(1'b0, 1'b1);
            send_beat_random_ready();
        end
        idle(10, 1'b1);
        check("t3_drained", EXP_W'(exp_q.size()), EXP_W'(0));

        // Fill the pipe against a blocked sink, then reset mid-stream.
        repeat (10) begin
            rand_beat(1'b1, 1'b0);
            drive_cycle(1'b0);
        end
        check("t4_full_valid", EXP_W'(hash_valid_o), EXP_W'(1));
        check("t4_full_ready", EXP_W'(windows_ready_o), EXP_W'(0));
        do_reset();
        rand_beat(1'b1, 1'b0);
        drive_cycle(1'b1);
        check("t4_accept", EXP_W'(last_acc), EXP_W'(1));
        wait_latency("t4_latency", got);

`ifdef WINDOW_HASH_PIPE_STAT_EN
        do_reset();
        repeat (7) begin
            rand_beat(1'b1, 1'b0);
            drive_cycle(1'b1);
        end
        idle(3, 1'b0);
        idle(10, 1'b1);
        check("t6_beats", EXP_W'(stat_beats_o), EXP_W'(7));
        check("t6_stalls", EXP_W'(stat_stall_o), EXP_W'(3));
`endif

        idle(8, 1'b1);
        check("final_queue_empty", EXP_W'(exp_q.size()), EXP_W'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
